// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-side execution resources: the MUL sequencer state encoding
// and the sizing helper for its step counter.
package alu_pkg;

  // 2'd3 is not a legal state; the sequencer recovers from it to StIdle.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Start/operand/result bundle between the CPU control unit (master) and the MUL sequencer (slave).
interface mul_seq_ctrl_if #(
  parameter int unsigned W = 8
) ();

  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  modport master (
    output start, a, b,
    input  busy, done, product
  );

  modport slave (
    input  start, a, b,
    output busy, done, product
  );

endinterface

// File: rtl/mul_seq_ctrl_and.sv
// Gate-level bitwise AND, used as the multiplier's partial-product generator.
module AND #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_y
);

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    and u_and (o_y[gi], i_a[gi], i_b[gi]);
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Shift-and-add unsigned W x W multiplier sequencer: one operation at a time, W steps,
// 2W-bit registered product with a one-cycle done pulse.
module mul_seq_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  mul_seq_ctrl_if.slave bus
);

  localparam int unsigned CntW = cnt_width(W);

  state_e          r_state;
  state_e          w_state_d;
  logic            r_busy;
  logic            r_done;
  logic [2*W-1:0]  r_product;
  logic [W-1:0]    r_mcand;
  logic [2*W-1:0]  r_acc;
  logic [CntW-1:0] r_cnt;

  logic            w_accept;
  logic            w_last;
  logic [W-1:0]    w_pp;
  logic [W:0]      w_sum;
  logic [2*W-1:0]  w_acc_step;

  AND #(
    .W (W)
  ) u_pp_and (
    .i_a (r_mcand),
    .i_b ({W{r_acc[0]}}),
    .o_y (w_pp)
  );

  // Carry lands in the top bit, so the shifted accumulator never overflows 2W bits.
  assign w_sum      = {1'b0, r_acc[2*W-1:W]} + {1'b0, w_pp};
  assign w_acc_step = {w_sum, r_acc[W-1:1]};
  assign w_last     = (r_cnt == CntW'(W - 1));

  always_comb begin
    w_state_d = r_state;
    w_accept  = 1'b0;
    case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_accept  = 1'b1;
          w_state_d = StRun;
        end
      end
      StRun: begin
        if (w_last) begin
          w_state_d = StDone;
        end
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // busy/done are registered from the next state so they carry no input-to-output path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_busy  <= (w_state_d == StRun) || (w_state_d == StDone);
      r_done  <= (w_state_d == StDone);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_product <= '0;
    end else if (w_accept) begin
      r_mcand <= bus.a;
      r_acc   <= {{W{1'b0}}, bus.b};
      r_cnt   <= '0;
    end else if (r_state == StRun) begin
      r_acc <= w_acc_step;
      r_cnt <= r_cnt + CntW'(1);
      if (w_last) begin
        r_product <= w_acc_step;
      end
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule
